mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage data access of the pipelined CPU.
- Runs a request/ack handshake on the memory side and a request/ready handshake per requester.
- Drives stall-relevant ready pulses back to the pipeline.
- Data access has priority; an anti-starvation counter guarantees fetch progress.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, consecutive DM grants (with IF waiting) after which the next grant goes to IF; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request; held until if_ready
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched instruction; valid while if_ready=1
if_ready  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held until dm_ready
dm_we  in  1  1 = store, 0 = load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_type  in  3  DMType access size/sign code, passed through unchanged
dm_rdata  out  DW  load data; valid while dm_ready=1
dm_ready  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_type  out  3  access type to memory
mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
mem_rdata  in  DW  memory read data

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - State IDLE; starve counter 0.
  - mem_req, mem_we, if_ready, dm_ready = 0.
  - mem_addr, mem_wdata, mem_type, if_rdata, dm_rdata = 0.
- States: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE:
  - dm_req=1 and (if_req=0 or starve<STARVE_MAX) -> BUSY_DM.
  - Otherwise if_req=1 -> BUSY_IF.
  - The selected requester's addr/wdata/we/type are registered into the mem_* outputs. mem_req=1 from the next cycle.
  - IF grant: mem_we=0, mem_type=word.
- BUSY_x:
  - mem_req held with stable mem_* outputs until mem_ack=1.
  - On ack: capture mem_rdata into x_rdata, drop mem_req, go to RESP.
- RESP:
  - Pulse x_ready for exactly one cycle, then go to IDLE.
  - No new grant is issued in this cycle: one bubble cycle between transactions.
- Minimum latency: req sampled at edge N, mem_req high at N+1. With ack in the same cycle, ready is high during cycle N+2.
- Starve counter:
  - Increments on each DM grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on every IF grant.
  - Clears on a DM grant made with if_req=0.
- mem_ack outside BUSY_x is ignored; no state change, no ready pulse.
- Requesters must hold req and payload stable until ready. A req dropped mid-transaction does not abort it; ready still pulses.
- Store completion: dm_ready pulses. dm_rdata takes mem_rdata as-is and is don't-care for the pipeline.
- rst asserted mid-transaction:
  - Next edge forces reset values; mem_req drops.
  - The in-flight access is abandoned and no ready pulse is issued.
  - The memory model must tolerate the dropped request.
- if_ready and dm_ready are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_if_cnt[31:0] and perf_dm_cnt[31:0].
  - Each counts completed transactions (ready pulses) of its requester.
  - Adds perf_wait_cnt[31:0], counting cycles in which a req is high but not yet granted.
  - All counters wrap modulo 2^32 and reset to 0.
- Undefined: the ports and the logic are absent; behaviour otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - State encoding constants: IDLE=2'b00, BUSY_IF=2'b01, BUSY_DM=2'b10, RESP=2'b11.
  - DMType constants shared with the decoder: byte, half, word, byte_unsigned, half_unsigned.
  - The IF access type constant (word).
- Sub-module mem_arb_pick: combinational grant selection (dm_req, if_req, starve count, STARVE_MAX -> grant_if/grant_dm) plus the saturating starve counter register. It is small, reusable and unit-testable.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0010, ack on the first mem_req cycle with rdata=0x0010_0093 -> if_ready high at cycle 2 after the request edge, if_rdata=0x0010_0093, mem_we=0.
- Store: dm_req=1, dm_we=1, addr=0x100, wdata=0xDEAD_BEEF, type=byte -> mem_we=1, mem_type=byte, mem_wdata=0xDEAD_BEEF held through 3 wait cycles, dm_ready one pulse after ack.
- Contention, STARVE_MAX=4: if_req and dm_req both held continuously -> grant order DM, DM, DM, DM, IF, DM, DM, DM, DM, IF. No simultaneous ready pulses.
- Spurious ack: mem_ack=1 while IDLE for 3 cycles -> no ready pulse, state stays IDLE.
- Reset mid-op: rst=1 during BUSY_DM before ack -> mem_req=0 next cycle, dm_ready never pulses. After reset release, a fresh IF request completes normally.
- MEM_ARB_PERF_EN build: 5 fetches + 3 loads completed -> perf_if_cnt=5, perf_dm_cnt=3. The counter preloaded to 0xFFFF_FFFF wraps to 0 on the next fetch.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and access-type codes for the memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_DM = 2'b10,
        RESP    = 2'b11
    } state_t;
    localparam logic [2:0] DM_BYTE   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_WORD   = 3'b010;
    localparam logic [2:0] DM_BYTE_U = 3'b100;
    localparam logic [2:0] DM_HALF_U = 3'b101;
    localparam logic [2:0] IF_TYPE   = DM_WORD;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-priority grant selection with a saturating anti-starvation counter
module mem_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic if_req,
    input  logic dm_req,
    output logic grant_if,
    output logic grant_dm
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve;
    always_comb begin
        grant_dm = en && dm_req && (!if_req || starve < SMAX);
        grant_if = en && if_req && !grant_dm;
    end
    // only DM grants made while IF is waiting count towards starvation
    always_ff @(posedge clk) begin
        if (rst || grant_if)
            starve <= '0;
        else if (grant_dm)
            starve <= !if_req ? '0 : (starve == SMAX ? starve : starve + 4'd1);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [2:0]    dm_type,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_type,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
   ,output logic [31:0]   perf_if_cnt,
    output logic [31:0]   perf_dm_cnt,
    output logic [31:0]   perf_wait_cnt
`endif
);
    state_t state;
    logic   grant_if, grant_dm;

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk      (clk),
        .rst      (rst),
        .en       (state == IDLE),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .grant_if (grant_if),
        .grant_dm (grant_dm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_type  <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= BUSY_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_type  <= dm_type;
                    end else if (grant_if) begin
                        state    <= BUSY_IF;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        mem_type <= IF_TYPE;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                    end
                end
                BUSY_DM: begin
                    if (mem_ack) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        dm_rdata <= mem_rdata;
                        dm_ready <= 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    // a requester is waiting while it asks but is neither granted, in service nor completing
    logic waiting;
    always_comb
        waiting = (if_req && !grant_if && state != BUSY_IF && !if_ready) ||
                  (dm_req && !grant_dm && state != BUSY_DM && !dm_ready);
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_cnt   <= '0;
            perf_dm_cnt   <= '0;
            perf_wait_cnt <= '0;
        end else begin
            perf_if_cnt   <= perf_if_cnt + 32'(if_ready);
            perf_dm_cnt   <= perf_dm_cnt + 32'(dm_ready);
            perf_wait_cnt <= perf_wait_cnt + 32'(waiting);
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [2:0]  dm_type;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_req, mem_we;
    logic [2:0]  mem_type;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_cnt, perf_dm_cnt, perf_wait_cnt;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_type(dm_type), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
       ,.perf_if_cnt(perf_if_cnt), .perf_dm_cnt(perf_dm_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // transaction-level model: who owns the memory, and what each output should show
    int          m_phase, m_who, m_starve, m_if_done, m_dm_done;
    logic        e_mem_req, e_mem_we, e_if_ready, e_dm_ready;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_dm_rdata;
    logic [2:0]  e_mem_type;

    task automatic predict();
        if (rst) begin
            m_phase = 0; m_starve = 0; m_if_done = 0; m_dm_done = 0;
            e_mem_req = 0; e_mem_we = 0; e_if_ready = 0; e_dm_ready = 0;
            e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_dm_rdata = 0; e_mem_type = 0;
        end else if (m_phase == 0) begin
            if (dm_req && (!if_req || m_starve < SM)) begin
                m_starve = if_req ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
                m_who = 2; m_phase = 1; e_mem_req = 1;
                e_mem_we = dm_we; e_mem_addr = dm_addr; e_mem_wdata = dm_wdata; e_mem_type = dm_type;
            end else if (if_req) begin
                m_starve = 0; m_who = 1; m_phase = 1; e_mem_req = 1;
                e_mem_we = 0; e_mem_addr = if_addr; e_mem_type = 3'b010;
            end
        end else if (m_phase == 1) begin
            if (mem_ack) begin
                m_phase = 2; e_mem_req = 0;
                if (m_who == 1) begin e_if_rdata = mem_rdata; e_if_ready = 1; m_if_done++; end
                else begin e_dm_rdata = mem_rdata; e_dm_ready = 1; m_dm_done++; end
            end
        end else begin
            m_phase = 0; e_if_ready = 0; e_dm_ready = 0;
        end
    endtask

    task automatic compare();
        check("mem_req", mem_req, e_mem_req);
        check("if_ready", if_ready, e_if_ready);
        check("dm_ready", dm_ready, e_dm_ready);
        check("mem_we", mem_we, e_mem_we);
        check("mem_addr", mem_addr, e_mem_addr);
        check("mem_type", mem_type, e_mem_type);
        check("if_rdata", if_rdata, e_if_rdata);
        check("dm_rdata", dm_rdata, e_dm_rdata);
        check("ready_excl", if_ready & dm_ready, 0);
        if (e_mem_req && e_mem_we) check("mem_wdata", mem_wdata, e_mem_wdata);
    endtask

    task automatic tick();
        predict();
        @(negedge clk);
        compare();
    endtask

    int   grants;
    logic prev_req;

    initial begin
        rst = 1; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_type = 0; mem_rdata = 0;
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ready", {if_ready, dm_ready}, 0);
        rst = 0;

        // single fetch with immediate ack
        if_req = 1; if_addr = 32'h0000_0010;
        tick();
        check("fetch_mem_req", mem_req, 1);
        check("fetch_mem_we", mem_we, 0);
        mem_ack = 1; mem_rdata = 32'h0010_0093;
        tick();
        check("fetch_ready", if_ready, 1);
        check("fetch_rdata", if_rdata, 32'h0010_0093);
        mem_ack = 0; if_req = 0;
        tick();
        check("fetch_ready_drop", if_ready, 0);

        // byte store with three wait cycles
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_type = 3'b000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("store_hold", {mem_req, mem_we, mem_wdata}, {2'b11, 32'hDEAD_BEEF});
        end
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        tick();
        check("store_ready", dm_ready, 1);
        mem_ack = 0; dm_req = 0; dm_we = 0;
        tick();
        check("store_ready_drop", dm_ready, 0);

        // spurious ack while idle
        mem_ack = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("spurious", {mem_req, if_ready, dm_ready}, 0);
        end
        mem_ack = 0;
        tick();

        // contention: every (SM+1)-th grant must go to IF
        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_addr = 32'h100; dm_type = 3'b010;
        grants = 0; prev_req = 0;
        for (int c = 0; c < 200 && grants < 10; c++) begin
            mem_ack = e_mem_req; mem_rdata = $urandom;
            tick();
            if (mem_req && !prev_req) begin
                check("grant_order", mem_addr == 32'h10, (grants % (SM + 1)) == SM);
                grants++;
            end
            prev_req = mem_req;
        end
        check("grant_count", grants, 10);
        if_req = 0; dm_req = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = e_mem_req;
            tick();
        end
        mem_ack = 0;

        // reset in the middle of a data access
        dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        tick(); tick();
        rst = 1; dm_req = 0;
        tick();
        check("rst_midop_req", mem_req, 0);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_midop_noready", dm_ready, 0);
        end
        if_req = 1; if_addr = 32'h44;
        grants = 0;
        for (int c = 0; c < 10 && grants == 0; c++) begin
            mem_ack = e_mem_req; mem_rdata = 32'hCAFE_0044;
            tick();
            if (if_ready) grants = 1;
        end
        check("rst_then_fetch", grants, 1);
        check("rst_then_rdata", if_rdata, 32'hCAFE_0044);
        if_req = 0; mem_ack = 0;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!if_req || e_if_ready) begin
                if_req = ($urandom % 3) != 0;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_req || e_dm_ready) begin
                dm_req = ($urandom % 2) != 0;
                dm_we = $urandom % 2;
                dm_addr = $urandom;
                dm_wdata = $urandom;
                dm_type = 3'($urandom % 6);
            end
            mem_ack = e_mem_req ? (($urandom % 3) == 0) : (($urandom % 6) == 0);
            mem_rdata = $urandom;
            rst = ($urandom % 400) == 0;
            tick();
        end
        rst = 0;
`ifdef MEM_ARB_PERF_EN
        check("perf_if", perf_if_cnt, m_if_done);
        check("perf_dm", perf_dm_cnt, m_dm_done);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
